// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// transmitter handshake timing.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        SEND    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } arb_state_t;

    // Cycles to wait for ready to drop before assuming the byte was taken.
    localparam int WAIT_LO_TIMEOUT = 4;

    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester at or after ptr that is
// both requesting and enabled by mask wins.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos] && mask[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_ctrl between N_REQ byte streams,
// with optional packet lock and send/ready handshake sequencing.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LOCK_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_send,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     locked,
    output logic                     busy,
    output logic [CNT_W-1:0]         sent_count
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WC_W  = $clog2(WAIT_LO_TIMEOUT);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [WC_W-1:0]  wait_cnt;
    logic             last_q;
    logic [N_REQ-1:0] lock_mask;
    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             accept;

    always_comb begin
        lock_mask = '1;
        if (locked) begin
            lock_mask           = '0;
            lock_mask[grant_id] = 1'b1;
        end
    end

    rr_priority_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .mask  (lock_mask),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Qualified with rst_n so no accept pulse leaks out while reset is held.
    assign accept = rst_n && (state == ARB) && tx_ready && pick_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (accept) state_nxt = SEND;
            SEND:    state_nxt = WAIT_LO;
            WAIT_LO: if (!tx_ready || wait_cnt == '0) state_nxt = WAIT_HI;
            WAIT_HI: if (tx_ready) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        req_ready = accept ? pick_grant : '0;
        tx_send   = (state == SEND);
        busy      = (state != ARB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data    <= '0;
            last_q     <= 1'b0;
            grant_id   <= '0;
            locked     <= 1'b0;
            sent_count <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
        end else begin
            if (accept) begin
                tx_data  <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                last_q   <= req_last[pick_idx];
                grant_id <= pick_idx;
            end
            if (state == SEND) begin
                sent_count <= sent_count + 1'b1;
                wait_cnt   <= WC_W'(WAIT_LO_TIMEOUT - 1);
            end
            if (state == WAIT_LO && tx_ready && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            // Rotation and lock only advance once the transmitter is idle again.
            if (state == WAIT_HI && tx_ready) begin
                rr_ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
                if (LOCK_EN != 0)
                    locked <= ~last_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed phases plus randomized
// traffic checked against a queue-based arbitration model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*DW-1:0]  req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic             tx_send;
    logic [DW-1:0]    tx_data;
    logic             tx_ready;
    logic [1:0]       grant_id;
    logic             locked;
    logic             busy;
    logic [CW-1:0]    sent_count;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .LOCK_EN (1),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_send    (tx_send),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .locked     (locked),
        .busy       (busy),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    // Transmitter model: ready low from lo_dly to lo_dly+hi_len-1 cycles after send.
    int  lo_dly = 1;
    int  hi_len = 20;
    bit  force_low = 1'b0;
    bit  tx_act = 1'b0;
    int  tx_t = 0;

    always @(posedge clk) begin
        if (tx_send) begin
            tx_act <= 1'b1;
            tx_t   <= 1;
        end else if (tx_act && tx_t < 1000) begin
            tx_t <= tx_t + 1;
        end
    end

    assign tx_ready = !force_low &&
                      !(tx_act && lo_dly != 0 && tx_t >= lo_dly && tx_t < lo_dly + hi_len);

    typedef struct {
        logic [7:0] d;
        logic       l;
    } item_t;

    item_t        q[N][$];
    logic [N-1:0] en = '1;
    logic [7:0]   log_d[$];
    int           log_g[$];

    int         passed = 0;
    int         total = 0;
    int         m_ptr = 0;
    int         m_grant = 0;
    int         m_lock_id = 0;
    bit         m_locked = 1'b0;
    logic [7:0] m_byte = '0;
    int         m_cnt = 0;
    bit         send_due = 1'b0;
    int         cyc = 0;
    int         accepts = 0;
    int         last_send_cyc = -1;
    int         send_gap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v);
        if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic bit pending();
        bit p = send_due || busy;
        for (int i = 0; i < N; i++)
            if (q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic tick();
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        int           w;
        int           w_obs;
        item_t        it;
        for (int i = 0; i < N; i++) begin
            v[i] = en[i] && q[i].size() > 0;
            req_data[i*DW +: DW] = v[i] ? q[i][0].d : 8'h00;
            req_last[i]          = v[i] ? q[i][0].l : 1'b0;
        end
        req_valid = v;
        #1;
        chk("tx_send", tx_send, send_due);
        chk("tx_data", tx_data, m_byte);
        chk("sent_count", sent_count, m_cnt);
        chk("grant_id", grant_id, m_grant);
        if (send_due) begin
            if (last_send_cyc >= 0) send_gap = cyc - last_send_cyc;
            last_send_cyc = cyc;
            m_cnt    = (m_cnt + 1) % (1 << CW);
            send_due = 1'b0;
        end
        w       = pick(v);
        exp_rdy = (tx_ready && w >= 0) ? (N'(1) << w) : '0;
        if (req_ready !== '0) begin
            chk("req_ready", req_ready, exp_rdy);
            chk("locked_at_accept", locked, m_locked);
            w_obs = -1;
            for (int i = 0; i < N; i++)
                if (req_ready[i] && w_obs < 0) w_obs = i;
            if (w_obs >= 0 && v[w_obs]) begin
                it = q[w_obs].pop_front();
                log_d.push_back(it.d);
                log_g.push_back(w_obs);
                m_byte    = it.d;
                m_grant   = w_obs;
                m_ptr     = (w_obs + 1) % N;
                m_locked  = !it.l;
                m_lock_id = w_obs;
                send_due  = 1'b1;
                accepts++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_drain(input string tag, input int max);
        int n = 0;
        while (pending() && n < max) begin
            tick();
            n++;
        end
        chk(tag, (n < max), 1);
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_tx_send", tx_send, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_locked", locked, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sent_count", sent_count, 0);
        end
        m_ptr = 0; m_grant = 0; m_lock_id = 0; m_locked = 1'b0;
        m_byte = '0; m_cnt = 0; send_due = 1'b0; last_send_cyc = -1;
        for (int i = 0; i < N; i++) q[i].delete();
        log_d.delete();
        log_g.delete();
        en = '1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic item_t mk(input logic [7:0] d, input logic l);
        item_t it;
        it.d = d;
        it.l = l;
        return it;
    endfunction

    initial begin
        int n;
        int acc0;
        // Reset with every requester asserting and the transmitter idle.
        @(negedge clk);
        req_valid = '1;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        do_reset(1'b1);

        // Transmitter not ready at reset release: arbiter must hold in ARB.
        force_low = 1'b1;
        for (int i = 0; i < N; i++) q[i].push_back(mk(8'h10 + 8'(i), 1'b1));
        acc0 = accepts;
        for (int k = 0; k < 10; k++) tick();
        chk("hold_no_accept", accepts - acc0, 0);
        chk("hold_busy", busy, 0);
        force_low = 1'b0;
        run_drain("hold_drain", 400);
        for (int k = 0; k < 4; k++) chk("hold_order", log_g[k], k);

        // Single requester, slow transmitter.
        do_reset(1'b0);
        lo_dly = 1; hi_len = 20;
        q[0].push_back(mk(8'hA5, 1'b1));
        q[0].push_back(mk(8'h00, 1'b1));
        q[0].push_back(mk(8'hFF, 1'b1));
        run_drain("single_drain", 200);
        chk("single_len", log_d.size(), 3);
        chk("single_b0", log_d[0], 8'hA5);
        chk("single_b1", log_d[1], 8'h00);
        chk("single_b2", log_d[2], 8'hFF);
        chk("single_count", sent_count, 3);

        // Fairness: all requesters continuously valid.
        do_reset(1'b0);
        lo_dly = 2; hi_len = 3;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++) q[i].push_back(mk(8'h10 + 8'(i), 1'b1));
        run_drain("fair_drain", 600);
        for (int k = 0; k < 24; k++) begin
            chk("fair_gnt", log_g[k], k % 4);
            chk("fair_data", log_d[k], 8'h10 + 8'(k % 4));
        end

        // Packet lock: req1 packet must go out contiguously before req2.
        do_reset(1'b0);
        lo_dly = 1; hi_len = 5;
        q[1].push_back(mk(8'h41, 1'b0));
        q[1].push_back(mk(8'h41, 1'b0));
        q[1].push_back(mk(8'h42, 1'b1));
        q[2].push_back(mk(8'h5A, 1'b1));
        run_drain("lock_drain", 200);
        chk("lock_b0", log_d[0], 8'h41);
        chk("lock_b1", log_d[1], 8'h41);
        chk("lock_b2", log_d[2], 8'h42);
        chk("lock_b3", log_d[3], 8'h5A);
        chk("lock_g3", log_g[3], 2);
        chk("lock_released", locked, 0);

        // Packet lock with the owner idling mid-packet.
        do_reset(1'b0);
        q[1].push_back(mk(8'h41, 1'b0));
        q[1].push_back(mk(8'h41, 1'b0));
        q[1].push_back(mk(8'h42, 1'b1));
        q[2].push_back(mk(8'h5A, 1'b1));
        n = 0;
        while (log_d.size() < 1 && n < 200) begin tick(); n++; end
        chk("idle_first", log_d.size(), 1);
        en[1] = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        chk("idle_no_serve", log_d.size(), 1);
        chk("idle_locked", locked, 1);
        en[1] = 1'b1;
        run_drain("idle_drain", 200);
        chk("idle_b1", log_d[1], 8'h41);
        chk("idle_b2", log_d[2], 8'h42);
        chk("idle_b3", log_d[3], 8'h5A);

        // Reset while a lock is held and the transmitter is busy.
        do_reset(1'b0);
        lo_dly = 1; hi_len = 20;
        q[1].push_back(mk(8'h41, 1'b0));
        q[1].push_back(mk(8'h41, 1'b0));
        q[1].push_back(mk(8'h42, 1'b1));
        n = 0;
        while (!(log_d.size() == 2 && !tx_ready && busy && !send_due) && n < 300) begin
            tick();
            n++;
        end
        chk("midrst_reached", (n < 300), 1);
        chk("midrst_locked", locked, 1);
        req_valid = '1;
        do_reset(1'b1);
        for (int i = 0; i < N; i++) q[i].push_back(mk(8'h70 + 8'(i), 1'b1));
        run_drain("midrst_drain", 400);
        for (int k = 0; k < 4; k++) chk("midrst_order", log_g[k], k);

        // Transmitter that never drops ready: timeout path.
        do_reset(1'b0);
        lo_dly = 0;
        for (int k = 0; k < 5; k++) q[0].push_back(mk(8'($urandom), 1'b1));
        acc0 = accepts;
        run_drain("fast_drain", 200);
        chk("fast_gap", send_gap, 7);
        chk("fast_count", sent_count, accepts - acc0);
        chk("fast_len", log_d.size(), 5);

        // Randomized traffic with random valid gating and transmitter timing.
        do_reset(1'b0);
        for (int r = 0; r < 3; r++) begin
            lo_dly = $urandom_range(0, 2);
            hi_len = $urandom_range(1, 8);
            acc0 = accepts;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < 7; k++)
                    q[i].push_back(mk(8'($urandom), ($urandom_range(0, 2) == 0)));
                q[i].push_back(mk(8'($urandom), 1'b1));
            end
            n = 0;
            while (pending() && n < 5000) begin
                for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            en = '1;
            chk("rand_drain", (n < 5000), 1);
            chk("rand_accepts", accepts - acc0, 32);
        end

        // Counter wrap.
        do_reset(1'b0);
        lo_dly = 1; hi_len = 1;
        for (int k = 0; k < 1023; k++) q[0].push_back(mk(8'($urandom), 1'b1));
        run_drain("wrap_pre_drain", 8000);
        chk("wrap_pre", sent_count, 10'h3FF);
        q[0].push_back(mk(8'h5C, 1'b1));
        run_drain("wrap_drain", 50);
        chk("wrap_zero", sent_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
